// File: rtl/button_pkg.sv
// Shared state type, default tick counts and timer-width helper for the
// button gesture classifier.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    GAP,
    PRESS2,
    LONG
  } state_t;

  localparam int LONG_TICKS_DEF       = 50_000_000;
  localparam int DCLICK_GAP_TICKS_DEF = 25_000_000;
  localparam int REPEAT_TICKS_DEF     = 10_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold max_ticks-1.
  function automatic int cnt_w_for(input int max_ticks);
    return (max_ticks < 2) ? 1 : $clog2(max_ticks);
  endfunction

  localparam int CNT_W_DEF =
    cnt_w_for(max3(LONG_TICKS_DEF, DCLICK_GAP_TICKS_DEF, REPEAT_TICKS_DEF));

endpackage

// File: rtl/button_press_classifier_if.sv
// Button front-end to classifier link: debounced level and edge pulses in,
// one-cycle gesture pulses and busy flag out.
interface button_press_classifier_if;

  logic level;
  logic p_edge;
  logic n_edge;
  logic single_click;
  logic double_click;
  logic long_press;
  logic repeat_pulse;
  logic busy;

  modport master (
    output level, p_edge, n_edge,
    input  single_click, double_click, long_press, repeat_pulse, busy
  );

  modport slave (
    input  level, p_edge, n_edge,
    output single_click, double_click, long_press, repeat_pulse, busy
  );

endinterface

// File: rtl/press_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count compare
// against a limit supplied at run time.
module press_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear together with enable counts the clearing cycle as tick 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = enable_i ? CNT_W'(1) : '0;
    end else if (enable_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into single click, double click and
// long press pulses. Auto-repeat while held is built only with BTN_AUTOREPEAT_EN.
module button_press_classifier
  import button_pkg::*;
#(
  parameter int LONG_TICKS       = LONG_TICKS_DEF,
  parameter int DCLICK_GAP_TICKS = DCLICK_GAP_TICKS_DEF,
  parameter int REPEAT_TICKS     = REPEAT_TICKS_DEF,
  parameter int CNT_W            = CNT_W_DEF
) (
  input logic clk,
  input logic reset,
  button_press_classifier_if.slave btn
);

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(DCLICK_GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] SAT_LIM  = '1;

  if (LONG_TICKS < 2 || DCLICK_GAP_TICKS < 2 || REPEAT_TICKS < 2 ||
      CNT_W < cnt_w_for(max3(LONG_TICKS, DCLICK_GAP_TICKS, REPEAT_TICKS)))
  begin : g_param_check
    $error("button_press_classifier: tick counts must be >= 2 and fit in CNT_W");
  end

  state_t           state_q;
  logic             single_q;
  logic             double_q;
  logic             long_q;
  logic             busy_q;
  logic [CNT_W-1:0] tmr_limit;
  logic             tmr_tc;
  logic             tmr_clr;
  logic             tmr_en;
  logic             p_evt;
  logic             n_evt;
  logic             lost_rel;

  // A coincident press and release is a release.
  assign n_evt    = btn.n_edge;
  assign p_evt    = btn.p_edge & ~btn.n_edge;
  assign lost_rel = ~btn.level & ~btn.n_edge;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LIM = CNT_W'(REPEAT_TICKS - 1);
  logic repeat_q;
`endif

  always_comb begin
    tmr_limit = SAT_LIM;
    case (state_q)
      PRESS1:  tmr_limit = LONG_LIM;
      GAP:     tmr_limit = GAP_LIM;
`ifdef BTN_AUTOREPEAT_EN
      LONG:    tmr_limit = REP_LIM;
`endif
      default: tmr_limit = SAT_LIM;
    endcase
  end

  // Timer restarts on every transition; the repeat period restarts from zero.
  always_comb begin
    tmr_clr = 1'b0;
    tmr_en  = 1'b1;
    case (state_q)
      IDLE:   tmr_clr = p_evt;
      PRESS1: begin
        tmr_clr = n_evt | lost_rel | tmr_tc;
        tmr_en  = n_evt | lost_rel | ~tmr_tc;
      end
      GAP:    tmr_clr = p_evt | tmr_tc;
      PRESS2: tmr_clr = n_evt | lost_rel;
      LONG: begin
`ifdef BTN_AUTOREPEAT_EN
        tmr_clr = n_evt | lost_rel | tmr_tc;
        tmr_en  = ~tmr_tc;
`else
        tmr_clr = n_evt | lost_rel;
`endif
      end
      default: tmr_clr = 1'b1;
    endcase
  end

  press_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (tmr_clr),
    .enable_i (tmr_en),
    .limit_i  (tmr_limit),
    .tc_o     (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_q <= 1'b0;
`endif
    end else begin
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (p_evt) begin
            state_q <= PRESS1;
            busy_q  <= 1'b1;
          end
        end
        PRESS1: begin
          if (n_evt) begin
            state_q <= GAP;
          end else if (lost_rel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (tmr_tc) begin
            state_q <= LONG;
            long_q  <= 1'b1;
          end
        end
        GAP: begin
          if (p_evt) begin
            state_q <= PRESS2;
          end else if (tmr_tc) begin
            state_q  <= IDLE;
            single_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        PRESS2: begin
          if (n_evt) begin
            state_q  <= IDLE;
            double_q <= 1'b1;
            busy_q   <= 1'b0;
          end else if (lost_rel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        LONG: begin
          if (n_evt || lost_rel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (tmr_tc) begin
            repeat_q <= 1'b1;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign btn.single_click = single_q;
  assign btn.double_click = double_q;
  assign btn.long_press   = long_q;
  assign btn.busy         = busy_q;
`ifdef BTN_AUTOREPEAT_EN
  assign btn.repeat_pulse = repeat_q;
`else
  assign btn.repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// Scenario bench for button_press_classifier: expected pulses are queued when
// stimulus is applied and matched by a negedge monitor.
module tb_button_press_classifier;

  localparam int LT = 20;
  localparam int GT = 10;
  localparam int RT = 5;
  localparam int CW = 5;

  localparam int K_SINGLE = 0;
  localparam int K_DOUBLE = 1;
  localparam int K_LONG   = 2;
  localparam int K_REPEAT = 3;

  typedef struct {
    int cyc;
    int kind;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic [3:0] outs;
  exp_t mon_e;

  button_press_classifier_if bif ();

  button_press_classifier #(
    .LONG_TICKS       (LT),
    .DCLICK_GAP_TICKS (GT),
    .REPEAT_TICKS     (RT),
    .CNT_W            (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin
    outs = {bif.repeat_pulse, bif.long_press, bif.double_click, bif.single_click};
    if (outs != 4'b0000) begin
      n_vec++;
      if ($countones(outs) != 1) begin
        n_err++;
        $display("FAIL onehot: got outputs %b at cycle %0d required exactly one high", outs, cyc);
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (outs[k]) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: got kind %0d at cycle %0d required no pulse", k, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.kind != k) begin
            n_err++;
            $display("FAIL pulse: got kind %0d at cycle %0d required kind %0d at cycle %0d",
                     k, cyc, mon_e.kind, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic push(input int c, input int k);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  // Apply inputs for the current cycle, then return at the start of the next one.
  task automatic pulse(input logic p, input logic n, input logic lvl);
    bif.p_edge = p;
    bif.n_edge = n;
    bif.level  = lvl;
    @(posedge clk);
    #1;
    bif.p_edge = 1'b0;
    bif.n_edge = 1'b0;
  endtask

  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({bif.single_click, bif.double_click, bif.long_press, bif.repeat_pulse} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_pulses: got %b required 0000",
               {bif.single_click, bif.double_click, bif.long_press, bif.repeat_pulse});
    end
    n_vec++;
    if (bif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b required 0", bif.busy);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    goto(cyc + 3);
  endtask

  task automatic test_single_click();
    int base;
    base = cyc;
    pulse(1'b1, 1'b0, 1'b1);
    goto(base + 5);
    pulse(1'b0, 1'b1, 1'b0);
    push(base + 15, K_SINGLE);
    goto(base + 10);
    @(negedge clk);
    n_vec++;
    if (bif.busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy_gap: got %b required 1", bif.busy);
    end
    goto(base + 15);
    @(negedge clk);
    n_vec++;
    if (bif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy_end: got %b required 0", bif.busy);
    end
    goto(base + 35);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL single_missing: got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_double_click();
    int base;
    base = cyc;
    pulse(1'b1, 1'b0, 1'b1);
    goto(base + 5);
    pulse(1'b0, 1'b1, 1'b0);
    goto(base + 14);
    pulse(1'b1, 1'b0, 1'b1);
    goto(base + 17);
    pulse(1'b0, 1'b1, 1'b0);
    push(base + 18, K_DOUBLE);
    goto(base + 40);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL double_missing: got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_long_press();
    int base;
    base = cyc;
    pulse(1'b1, 1'b0, 1'b1);
    push(base + LT, K_LONG);
`ifdef BTN_AUTOREPEAT_EN
    push(base + LT + RT, K_REPEAT);
    push(base + LT + 2 * RT, K_REPEAT);
`endif
    goto(base + 25);
    @(negedge clk);
    n_vec++;
    if (bif.busy !== 1'b1) begin
      n_err++;
      $display("FAIL long_busy_held: got %b required 1", bif.busy);
    end
    goto(base + 30);
    pulse(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if (bif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL long_busy_release: got %b required 0", bif.busy);
    end
    goto(base + 50);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL long_missing: got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_long_boundary();
    int base;
    // Release on the terminal cycle: release wins, becomes a single click.
    base = cyc;
    pulse(1'b1, 1'b0, 1'b1);
    goto(base + LT - 1);
    pulse(1'b0, 1'b1, 1'b0);
    push(base + LT - 1 + GT, K_SINGLE);
    goto(base + 40);
    // Release one cycle later: long press, nothing after.
    base = cyc;
    pulse(1'b1, 1'b0, 1'b1);
    push(base + LT, K_LONG);
    goto(base + LT);
    pulse(1'b0, 1'b1, 1'b0);
    goto(base + 40);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL long_boundary_missing: got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = cyc;
    pulse(1'b1, 1'b0, 1'b1);
    goto(base + 5);
    pulse(1'b0, 1'b1, 1'b0);
    goto(base + 7);
    @(negedge clk);
    n_vec++;
    if (bif.busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_busy_before: got %b required 1", bif.busy);
    end
    goto(base + 8);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_busy_after: got %b required 0", bif.busy);
    end
    goto(base + 35);
  endtask

  task automatic test_both_edges();
    int base;
    base = cyc;
    pulse(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if (bif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL both_idle_busy: got %b required 0", bif.busy);
    end
    goto(base + 5);
    pulse(1'b1, 1'b0, 1'b1);
    goto(base + 8);
    pulse(1'b1, 1'b1, 1'b0);
    push(base + 18, K_SINGLE);
    goto(base + 40);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL both_missing: got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_gap_race();
    int base;
    base = cyc;
    pulse(1'b1, 1'b0, 1'b1);
    goto(base + 5);
    pulse(1'b0, 1'b1, 1'b0);
    goto(base + 14);
    pulse(1'b1, 1'b0, 1'b1);
    goto(base + 16);
    pulse(1'b0, 1'b1, 1'b0);
    push(base + 17, K_DOUBLE);
    goto(base + 40);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL gap_race_missing: got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stuck_level();
    int base;
    base = cyc;
    pulse(1'b1, 1'b0, 1'b1);
    goto(base + 3);
    @(negedge clk);
    n_vec++;
    if (bif.busy !== 1'b1) begin
      n_err++;
      $display("FAIL stuck_busy_before: got %b required 1", bif.busy);
    end
    goto(base + 4);
    pulse(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    if (bif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL stuck_busy_after: got %b required 0", bif.busy);
    end
    goto(base + 40);
  endtask

  task automatic test_back_to_back();
    int base;
    int h1;
    int g;
    int h2;
    for (int i = 0; i < 4; i++) begin
      h1 = int'($urandom_range(1, LT - 2));
      g  = int'($urandom_range(1, GT - 1));
      h2 = (i == 0) ? 40 : int'($urandom_range(1, 40));
      base = cyc;
      pulse(1'b1, 1'b0, 1'b1);
      goto(base + h1);
      pulse(1'b0, 1'b1, 1'b0);
      goto(base + h1 + g);
      pulse(1'b1, 1'b0, 1'b1);
      goto(base + h1 + g + h2);
      pulse(1'b0, 1'b1, 1'b0);
      push(base + h1 + g + h2 + 1, K_DOUBLE);
    end
    goto(cyc + 20);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_missing: got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    bif.level  = 1'b0;
    bif.p_edge = 1'b0;
    bif.n_edge = 1'b0;
    test_reset();
    test_single_click();
    test_double_click();
    test_long_press();
    test_long_boundary();
    test_reset_mid();
    test_both_edges();
    test_gap_race();
    test_stuck_level();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
